// File: rtl/memory_unit.sv
// memory_unit
//
// Sequences one instruction fetch and an optional data access per pipeline
// advance over two Wishbone-style slave ports. Both accesses are started
// together. Their results are held in `inst` and `rd_data`, and `mem_busy`
// holds the pipeline until every required access has been acknowledged.
//
// Bus handshake: a port's cyc/stb is raised at the edge that leaves IDLE.
// It stays high until the edge at which the slave's ack is sampled high
// together with stb. That edge is the transfer, and stb is dropped at that
// same edge. An ack seen while stb is low is ignored.
//
// Ports:
//   clock, reset          clock; asynchronous active-high reset
//   inst_mem_addr         fetch address (PC)
//   inst                  held fetched instruction
//   data_mem_addr         load/store address
//   wr_data               store data
//   mem_rd_en, mem_wr_en  load / store request (store wins if both are set)
//   mem_byte_en           byte lanes for the data access
//   rd_data               held load data
//   mem_busy              pipeline stall request (low only in DONE)
//   inst_cyc/stb/adr      fetch bus master outputs
//   inst_dat_i, inst_ack  fetch bus slave returns
//   data_cyc/stb/we/sel   data bus master outputs
//   data_adr, data_dat_o  data bus address and write data
//   data_dat_i, data_ack  data bus slave returns
//   debug_state           current FSM state (0 IDLE, 1 WAIT, 2 DONE)
//
// DATA_SIZE must be 32 or 64.
module memory_unit #(
  parameter int DATA_SIZE = 32
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic [DATA_SIZE-1:0]   inst_mem_addr,
  output logic [31:0]            inst,
  input  logic [DATA_SIZE-1:0]   data_mem_addr,
  input  logic [DATA_SIZE-1:0]   wr_data,
  input  logic                   mem_rd_en,
  input  logic                   mem_wr_en,
  input  logic [DATA_SIZE/8-1:0] mem_byte_en,
  output logic [DATA_SIZE-1:0]   rd_data,
  output logic                   mem_busy,
  output logic                   inst_cyc,
  output logic                   inst_stb,
  output logic [DATA_SIZE-1:0]   inst_adr,
  input  logic [31:0]            inst_dat_i,
  input  logic                   inst_ack,
  output logic                   data_cyc,
  output logic                   data_stb,
  output logic                   data_we,
  output logic [DATA_SIZE/8-1:0] data_sel,
  output logic [DATA_SIZE-1:0]   data_adr,
  output logic [DATA_SIZE-1:0]   data_dat_o,
  input  logic [DATA_SIZE-1:0]   data_dat_i,
  input  logic                   data_ack,
  output logic [1:0]             debug_state
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state;
  state_t state_next;

  logic inst_done;
  logic data_done;
  logic inst_hit;
  logic data_hit;

  // A transfer completes only when ack meets a live strobe.
  assign inst_hit = inst_stb & inst_ack;
  assign data_hit = data_stb & data_ack;

  // State register
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic. A port counts as finished if it already completed
  // earlier or completes at this edge.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: state_next = WAIT;
      WAIT: begin
        if ((inst_done || inst_hit) && (data_done || data_hit)) begin
          state_next = DONE;
        end
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Stall is decoded from the state register only, so no ack reaches it
  // combinationally.
  assign mem_busy    = (state != DONE);
  assign debug_state = state;

  // Bus master registers, completion flags and result hold registers
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      inst_cyc   <= 1'b0;
      inst_stb   <= 1'b0;
      inst_adr   <= '0;
      inst       <= '0;
      inst_done  <= 1'b0;
      data_cyc   <= 1'b0;
      data_stb   <= 1'b0;
      data_we    <= 1'b0;
      data_sel   <= '0;
      data_adr   <= '0;
      data_dat_o <= '0;
      rd_data    <= '0;
      data_done  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          inst_adr  <= inst_mem_addr;
          inst_cyc  <= 1'b1;
          inst_stb  <= 1'b1;
          inst_done <= 1'b0;
          if (mem_wr_en || mem_rd_en) begin
            data_adr   <= data_mem_addr;
            data_dat_o <= wr_data;
            data_sel   <= mem_byte_en;
            // A store takes priority when both enables are raised.
            data_we    <= mem_wr_en;
            data_cyc   <= 1'b1;
            data_stb   <= 1'b1;
            data_done  <= 1'b0;
          end else begin
            // No data access this advance: the data side is already done.
            data_done <= 1'b1;
          end
        end
        WAIT: begin
          if (inst_hit) begin
            inst      <= inst_dat_i;
            inst_done <= 1'b1;
            inst_cyc  <= 1'b0;
            inst_stb  <= 1'b0;
          end
          if (data_hit) begin
            // Stores leave the last load value in place.
            if (!data_we) begin
              rd_data <= data_dat_i;
            end
            data_done <= 1'b1;
            data_cyc  <= 1'b0;
            data_stb  <= 1'b0;
            data_we   <= 1'b0;
          end
        end
        DONE: begin
          inst_done <= 1'b0;
          data_done <= 1'b0;
        end
        default: begin
          inst_done <= 1'b0;
          data_done <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_memory_unit.sv
// tb_memory_unit
//
// Bench for memory_unit (DATA_SIZE = 32). Inputs are driven and outputs are
// sampled on the falling clock edge. The slave side acks on a chosen WAIT
// cycle, presents scrambled read data on every other cycle so that a capture
// at the wrong edge shows up, and can inject acks while stb is low. Expected
// values come from a transaction-level model: the stall lasts
// 2 + max(fetch wait, data wait) cycles, `inst` takes the last fetched word,
// and `rd_data` takes the last load (store wins over load).
module tb_memory_unit;

  localparam int DW = 32;
  localparam int SW = DW / 8;

  logic          clock;
  logic          reset;
  logic [DW-1:0] inst_mem_addr;
  logic [31:0]   inst;
  logic [DW-1:0] data_mem_addr;
  logic [DW-1:0] wr_data;
  logic          mem_rd_en;
  logic          mem_wr_en;
  logic [SW-1:0] mem_byte_en;
  logic [DW-1:0] rd_data;
  logic          mem_busy;
  logic          inst_cyc;
  logic          inst_stb;
  logic [DW-1:0] inst_adr;
  logic [31:0]   inst_dat_i;
  logic          inst_ack;
  logic          data_cyc;
  logic          data_stb;
  logic          data_we;
  logic [SW-1:0] data_sel;
  logic [DW-1:0] data_adr;
  logic [DW-1:0] data_dat_o;
  logic [DW-1:0] data_dat_i;
  logic          data_ack;
  logic [1:0]    debug_state;

  memory_unit #(.DATA_SIZE(DW)) dut (
    .clock        (clock),
    .reset        (reset),
    .inst_mem_addr(inst_mem_addr),
    .inst         (inst),
    .data_mem_addr(data_mem_addr),
    .wr_data      (wr_data),
    .mem_rd_en    (mem_rd_en),
    .mem_wr_en    (mem_wr_en),
    .mem_byte_en  (mem_byte_en),
    .rd_data      (rd_data),
    .mem_busy     (mem_busy),
    .inst_cyc     (inst_cyc),
    .inst_stb     (inst_stb),
    .inst_adr     (inst_adr),
    .inst_dat_i   (inst_dat_i),
    .inst_ack     (inst_ack),
    .data_cyc     (data_cyc),
    .data_stb     (data_stb),
    .data_we      (data_we),
    .data_sel     (data_sel),
    .data_adr     (data_adr),
    .data_dat_o   (data_dat_o),
    .data_dat_i   (data_dat_i),
    .data_ack     (data_ack),
    .debug_state  (debug_state)
  );

  // Clock / reset
  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Scoreboard and reference model state
  int          vectors;
  int          miscompares;
  logic [31:0] exp_q[$];
  logic [31:0] exp_inst;
  logic [DW-1:0] exp_rd;

  // One full pipeline advance. Called in the falling-edge half of an IDLE
  // cycle; returns in the falling-edge half of the following IDLE cycle.
  // iw / dw: WAIT cycle (1-based) on which each slave acks.
  task automatic run_txn(input string name, input logic rd, input logic wr,
                         input logic [DW-1:0] addr, input logic [DW-1:0] wdat,
                         input logic [SW-1:0] be, input logic [DW-1:0] iaddr,
                         input logic [31:0] idat, input logic [DW-1:0] ddat,
                         input int iw, input int dw, input logic spur);
    logic          acc;
    int            m;
    logic [31:0]   old_inst;
    logic [DW-1:0] old_rd;
    acc      = rd | wr;
    m        = iw;
    if (acc && dw > m) m = dw;
    old_inst = exp_inst;
    old_rd   = exp_rd;
    exp_q.push_back(idat);

    inst_mem_addr = iaddr;
    data_mem_addr = addr;
    wr_data       = wdat;
    mem_byte_en   = be;
    mem_rd_en     = rd;
    mem_wr_en     = wr;
    inst_dat_i    = ~idat;
    data_dat_i    = ~ddat;
    inst_ack      = spur;
    data_ack      = spur;

    vectors++;
    if (mem_busy !== 1'b1 || inst_stb !== 1'b0 || data_stb !== 1'b0) begin
      $display("FAIL %s idle: busy=%b inst_stb=%b data_stb=%b, required 1 0 0",
               name, mem_busy, inst_stb, data_stb);
      miscompares++;
    end

    for (int c = 1; c <= m + 1; c++) begin
      @(posedge clock);
      @(negedge clock);
      vectors++;
      if (mem_busy !== (c <= m)) begin
        $display("FAIL %s busy c%0d: got %b, required %b", name, c, mem_busy, (c <= m));
        miscompares++;
      end
      vectors++;
      if (inst_stb !== (c <= iw) || inst_cyc !== (c <= iw)) begin
        $display("FAIL %s inst_stb c%0d: got cyc=%b stb=%b, required %b",
                 name, c, inst_cyc, inst_stb, (c <= iw));
        miscompares++;
      end
      vectors++;
      if (data_stb !== (acc && c <= dw) || data_cyc !== (acc && c <= dw)) begin
        $display("FAIL %s data_stb c%0d: got cyc=%b stb=%b, required %b",
                 name, c, data_cyc, data_stb, (acc && c <= dw));
        miscompares++;
      end
      if (c <= iw) begin
        vectors++;
        if (inst_adr !== iaddr || inst !== old_inst) begin
          $display("FAIL %s fetch c%0d: adr=%h inst=%h, required %h %h",
                   name, c, inst_adr, inst, iaddr, old_inst);
          miscompares++;
        end
      end
      if (acc && c <= dw) begin
        vectors++;
        if (data_adr !== addr || data_dat_o !== wdat || data_sel !== be ||
            data_we !== wr || rd_data !== old_rd) begin
          $display("FAIL %s data c%0d: adr=%h dat=%h sel=%b we=%b rd=%h, required %h %h %b %b %h",
                   name, c, data_adr, data_dat_o, data_sel, data_we, rd_data,
                   addr, wdat, be, wr, old_rd);
          miscompares++;
        end
      end
      if (c == m + 1) begin
        exp_inst = exp_q.pop_front();
        if (rd && !wr) exp_rd = ddat;
        vectors++;
        if (inst !== exp_inst || rd_data !== exp_rd) begin
          $display("FAIL %s done: inst=%h rd_data=%h, required %h %h",
                   name, inst, rd_data, exp_inst, exp_rd);
          miscompares++;
        end
      end
      // Slave response for the edge ending this cycle
      inst_ack   = (c == iw) || (spur && c > iw);
      data_ack   = (acc && c == dw) || (spur && (!acc || c > dw));
      inst_dat_i = (c == iw) ? idat : ~idat;
      data_dat_i = (acc && c == dw) ? ddat : ~ddat;
    end

    @(posedge clock);
    @(negedge clock);
    vectors++;
    if (inst !== exp_inst || rd_data !== exp_rd || mem_busy !== 1'b1) begin
      $display("FAIL %s hold: inst=%h rd_data=%h busy=%b, required %h %h 1",
               name, inst, rd_data, mem_busy, exp_inst, exp_rd);
      miscompares++;
    end
    inst_ack = 1'b0;
    data_ack = 1'b0;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    inst_mem_addr = '0; data_mem_addr = '0; wr_data = '0;
    mem_rd_en = 1'b0; mem_wr_en = 1'b0; mem_byte_en = '0;
    inst_dat_i = '0; data_dat_i = '0; inst_ack = 1'b0; data_ack = 1'b0;
    exp_inst = '0;
    exp_rd   = '0;
    repeat (3) @(posedge clock);
    @(negedge clock);
    vectors++;
    if (inst_cyc !== 1'b0 || inst_stb !== 1'b0 || data_cyc !== 1'b0 ||
        data_stb !== 1'b0 || data_we !== 1'b0 || data_sel !== '0 ||
        inst_adr !== '0 || data_adr !== '0 || data_dat_o !== '0 ||
        inst !== '0 || rd_data !== '0 || mem_busy !== 1'b1) begin
      $display("FAIL reset_values: cyc/stb %b%b%b%b we=%b sel=%b adr=%h/%h dat=%h inst=%h rd=%h busy=%b",
               inst_cyc, inst_stb, data_cyc, data_stb, data_we, data_sel,
               inst_adr, data_adr, data_dat_o, inst, rd_data, mem_busy);
      miscompares++;
    end
    reset = 1'b0;
  endtask

  task automatic test_fetch_zero_wait;
    for (int i = 0; i < 3; i++) begin
      run_txn("fetch_zero_wait", 1'b0, 1'b0, 32'h0, 32'h0, 4'h0,
              32'h40, 32'h00500093, 32'h0, 1, 1, 1'b0);
    end
  endtask

  task automatic test_fetch_load_skewed;
    run_txn("fetch_load_skewed", 1'b1, 1'b0, 32'h200, 32'h0, 4'hF,
            32'h44, 32'h00A00113, 32'hCAFEF00D, 2, 4, 1'b0);
  endtask

  task automatic test_store;
    run_txn("store", 1'b0, 1'b1, 32'h100, 32'hDEADBEEF, 4'b0011,
            32'h48, 32'h00112023, 32'h13572468, 1, 2, 1'b0);
  endtask

  task automatic test_simultaneous_spurious;
    run_txn("simultaneous_acks", 1'b1, 1'b0, 32'h300, 32'h0, 4'hF,
            32'h4C, 32'h12345678, 32'h0BADCAFE, 1, 1, 1'b1);
    run_txn("spurious_fetch_only", 1'b0, 1'b0, 32'h0, 32'h0, 4'h0,
            32'h50, 32'h9ABCDEF0, 32'h0, 2, 1, 1'b1);
  endtask

  task automatic test_reset_in_wait;
    inst_mem_addr = 32'h80; mem_rd_en = 1'b1; mem_wr_en = 1'b0;
    data_mem_addr = 32'h400; mem_byte_en = 4'hF;
    inst_ack = 1'b0; data_ack = 1'b0;
    @(posedge clock);
    @(negedge clock);
    @(posedge clock);
    @(negedge clock);
    reset = 1'b1;
    #1;
    exp_inst = '0;
    exp_rd   = '0;
    vectors++;
    if (inst_cyc !== 1'b0 || inst_stb !== 1'b0 || data_cyc !== 1'b0 ||
        data_stb !== 1'b0 || inst !== '0 || rd_data !== '0 || mem_busy !== 1'b1) begin
      $display("FAIL reset_in_wait: cyc/stb %b%b%b%b inst=%h rd=%h busy=%b, required 0000 0 0 1",
               inst_cyc, inst_stb, data_cyc, data_stb, inst, rd_data, mem_busy);
      miscompares++;
    end
    @(negedge clock);
    reset = 1'b0;
    run_txn("after_reset", 1'b0, 1'b0, 32'h0, 32'h0, 4'h0,
            32'h80, 32'hFEEDFACE, 32'h0, 1, 1, 1'b0);
  endtask

  task automatic test_back_to_back;
    run_txn("b2b_load", 1'b1, 1'b0, 32'h500, 32'h0, 4'hF,
            32'h84, 32'h00000013, 32'h55AA55AA, 1, 2, 1'b0);
    for (int i = 0; i < 4; i++) begin
      run_txn("b2b_rdwr", 1'b1, 1'b1, 32'h600 + i * 4, $urandom, 4'hF,
              32'h88 + i * 4, $urandom, $urandom, $urandom_range(1, 2),
              $urandom_range(1, 2), 1'b0);
    end
  endtask

  task automatic test_random;
    for (int i = 0; i < 24; i++) begin
      run_txn("random", 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
              $urandom, $urandom, 4'($urandom_range(0, 15)), $urandom,
              $urandom, $urandom, $urandom_range(1, 4), $urandom_range(1, 4),
              1'($urandom_range(0, 1)));
    end
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    test_reset();
    test_fetch_zero_wait();
    test_fetch_load_skewed();
    test_store();
    test_simultaneous_spurious();
    test_reset_in_wait();
    test_back_to_back();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
